// File: rtl/cordic_sched.sv
// cordic_sched: round-robin scheduler and result router for one pipelined
// CORDIC core. Requests from up to nch channels are issued one per cycle. A
// tag delay line, matched to the core latency, carries each request's channel
// and op. Each result then returns to the channel it came from, with that op.
module cordic_sched #(
  parameter int width = 18,
  parameter int nstg  = 20,
  parameter int nch   = 4,
  parameter int chw   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [nch-1:0]              req_valid,
  output logic [nch-1:0]              req_ready,
  input  logic [2*nch-1:0]            req_op,
  input  logic [width*nch-1:0]        req_x,
  input  logic [width*nch-1:0]        req_y,
  input  logic [(width+1)*nch-1:0]    req_p,
  output logic [1:0]                  c_op,
  output logic [width-1:0]            c_x,
  output logic [width-1:0]            c_y,
  output logic [width:0]              c_p,
  input  logic [width-1:0]            c_xout,
  input  logic [width-1:0]            c_yout,
  input  logic [width:0]              c_pout,
  output logic                        res_valid,
  output logic [chw-1:0]              res_ch,
  output logic [1:0]                  res_op,
  output logic [width-1:0]            res_x,
  output logic [width-1:0]            res_y,
  output logic [width:0]              res_p,
  output logic [chw+5:0]              inflight
);

  localparam logic [chw+5:0] ONE_CNT = {{(chw+5){1'b0}}, 1'b1};
  localparam logic [chw-1:0] LAST_RST = chw'(nch - 1);

  // round-robin pointer: channel of the most recent transfer
  logic [chw-1:0]   r_last;

  // issue register feeding the CORDIC input port
  logic [1:0]       r_c_op;
  logic [width-1:0] r_c_x;
  logic [width-1:0] r_c_y;
  logic [width:0]   r_c_p;

  // tag line, entry nstg is the oldest
  logic             r_tv  [0:nstg];
  logic [chw-1:0]   r_tch [0:nstg];
  logic [1:0]       r_top [0:nstg];

  // result register
  logic             r_res_valid;
  logic [chw-1:0]   r_res_ch;
  logic [1:0]       r_res_op;
  logic [width-1:0] r_res_x;
  logic [width-1:0] r_res_y;
  logic [width:0]   r_res_p;
  logic [chw+5:0]   r_inflight;

  // arbiter results
  logic             w_found;
  logic             w_hit;
  logic [chw-1:0]   w_gidx;
  logic             w_xfer;
  logic [nch-1:0]   w_ready;
  logic [1:0]       w_op;
  logic [width-1:0] w_x;
  logic [width-1:0] w_y;
  logic [width:0]   w_p;
  int               w_idx;

  // round-robin search starting after r_last; the grant is held off during reset
  always_comb begin
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_gidx  = '0;
    w_idx   = 0;
    for (int k = 1; k <= nch; k++) begin
      w_idx   = (int'(r_last) + k) % nch;
      w_hit   = !w_found && req_valid[w_idx];
      w_gidx  = w_hit ? chw'(w_idx) : w_gidx;
      w_found = w_found | w_hit;
    end
    w_xfer  = w_found & ~rst;
    w_ready = '0;
    for (int i = 0; i < nch; i++) begin
      w_ready[i] = w_xfer && (w_gidx == chw'(i));
    end
    w_op = req_op[2*int'(w_gidx) +: 2];
    w_x  = req_x[width*int'(w_gidx) +: width];
    w_y  = req_y[width*int'(w_gidx) +: width];
    w_p  = req_p[(width+1)*int'(w_gidx) +: (width+1)];
  end

  assign req_ready = w_ready;

  // arbiter pointer follows the granted channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= LAST_RST;
    end else if (w_xfer) begin
      r_last <= w_gidx;
    end else begin
      r_last <= r_last;
    end
  end

  // issue register: granted channel's fields, or zero when nothing transfers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_op <= 2'b00;
      r_c_x  <= '0;
      r_c_y  <= '0;
      r_c_p  <= '0;
    end else if (w_xfer) begin
      r_c_op <= w_op;
      r_c_x  <= w_x;
      r_c_y  <= w_y;
      r_c_p  <= w_p;
    end else begin
      r_c_op <= 2'b00;
      r_c_x  <= '0;
      r_c_y  <= '0;
      r_c_p  <= '0;
    end
  end

  // tag line shifts every cycle since the CORDIC never stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= nstg; i++) begin
        r_tv[i]  <= 1'b0;
        r_tch[i] <= '0;
        r_top[i] <= 2'b00;
      end
    end else begin
      r_tv[0]  <= w_xfer;
      r_tch[0] <= w_gidx;
      r_top[0] <= w_op;
      for (int i = 1; i <= nstg; i++) begin
        r_tv[i]  <= r_tv[i-1];
        r_tch[i] <= r_tch[i-1];
        r_top[i] <= r_top[i-1];
      end
    end
  end

  // result register: data captured every cycle, tag from the oldest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_ch    <= '0;
      r_res_op    <= 2'b00;
      r_res_x     <= '0;
      r_res_y     <= '0;
      r_res_p     <= '0;
    end else begin
      r_res_valid <= r_tv[nstg];
      r_res_ch    <= r_tch[nstg];
      r_res_op    <= r_top[nstg];
      r_res_x     <= c_xout;
      r_res_y     <= c_yout;
      r_res_p     <= c_pout;
    end
  end

  // in-flight count; the decrement tracks the entry about to become res_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_xfer, r_tv[nstg]})
        2'b10:   r_inflight <= r_inflight + ONE_CNT;
        2'b01:   r_inflight <= r_inflight - ONE_CNT;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign c_op      = r_c_op;
  assign c_x       = r_c_x;
  assign c_y       = r_c_y;
  assign c_p       = r_c_p;
  assign res_valid = r_res_valid;
  assign res_ch    = r_res_ch;
  assign res_op    = r_res_op;
  assign res_x     = r_res_x;
  assign res_y     = r_res_y;
  assign res_p     = r_res_p;
  assign inflight  = r_inflight;

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: directed and random checks of the scheduler against an
// arbiter/scoreboard model and a stand-in CORDIC pipeline.
module tb_cordic_sched;

  localparam int W    = 18;
  localparam int NSTG = 20;
  localparam int NCH  = 4;
  localparam int CHW  = 2;
  localparam int LAT  = NSTG + 1;

  logic                     clk;
  logic                     rst;
  logic [NCH-1:0]           req_valid;
  logic [NCH-1:0]           req_ready;
  logic [2*NCH-1:0]         req_op;
  logic [W*NCH-1:0]         req_x;
  logic [W*NCH-1:0]         req_y;
  logic [(W+1)*NCH-1:0]     req_p;
  logic [1:0]               c_op;
  logic [W-1:0]             c_x;
  logic [W-1:0]             c_y;
  logic [W:0]               c_p;
  logic [W-1:0]             c_xout;
  logic [W-1:0]             c_yout;
  logic [W:0]               c_pout;
  logic                     res_valid;
  logic [CHW-1:0]           res_ch;
  logic [1:0]               res_op;
  logic [W-1:0]             res_x;
  logic [W-1:0]             res_y;
  logic [W:0]               res_p;
  logic [CHW+5:0]           inflight;

  cordic_sched #(.width(W), .nstg(NSTG), .nch(NCH), .chw(CHW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_p(req_p),
    .c_op(c_op), .c_x(c_x), .c_y(c_y), .c_p(c_p),
    .c_xout(c_xout), .c_yout(c_yout), .c_pout(c_pout),
    .res_valid(res_valid), .res_ch(res_ch), .res_op(res_op),
    .res_x(res_x), .res_y(res_y), .res_p(res_p),
    .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stand-in CORDIC: NSTG-stage pipe, output x+1, ~y, p
  logic [W-1:0] m_px [0:NSTG-1];
  logic [W-1:0] m_py [0:NSTG-1];
  logic [W:0]   m_pp [0:NSTG-1];
  always_ff @(posedge clk) begin
    m_px[0] <= c_x;
    m_py[0] <= c_y;
    m_pp[0] <= c_p;
    for (int i = 1; i < NSTG; i++) begin
      m_px[i] <= m_px[i-1];
      m_py[i] <= m_py[i-1];
      m_pp[i] <= m_pp[i-1];
    end
  end
  assign c_xout = m_px[NSTG-1] + 18'd1;
  assign c_yout = ~m_py[NSTG-1];
  assign c_pout = m_pp[NSTG-1];

  // per-channel stimulus, packed onto the request buses
  logic [1:0]   s_op [NCH];
  logic [W-1:0] s_x  [NCH];
  logic [W-1:0] s_y  [NCH];
  logic [W:0]   s_p  [NCH];
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      req_op[2*i +: 2]       = s_op[i];
      req_x[W*i +: W]        = s_x[i];
      req_y[W*i +: W]        = s_y[i];
      req_p[(W+1)*i +: (W+1)] = s_p[i];
    end
  end

  typedef struct {
    logic [CHW-1:0] ch;
    logic [1:0]     op;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [W:0]     p;
    int             due;
  } exp_t;

  exp_t q[$];
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   m_last;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_zero();
    check_val("rst_ready", 64'(req_ready), 64'd0);
    check_val("rst_c_op", 64'(c_op), 64'd0);
    check_val("rst_c_x", 64'(c_x), 64'd0);
    check_val("rst_c_y", 64'(c_y), 64'd0);
    check_val("rst_c_p", 64'(c_p), 64'd0);
    check_val("rst_res_valid", 64'(res_valid), 64'd0);
    check_val("rst_res_ch", 64'(res_ch), 64'd0);
    check_val("rst_res_op", 64'(res_op), 64'd0);
    check_val("rst_res_x", 64'(res_x), 64'd0);
    check_val("rst_res_y", 64'(res_y), 64'd0);
    check_val("rst_res_p", 64'(res_p), 64'd0);
    check_val("rst_inflight", 64'(inflight), 64'd0);
  endtask

  // asynchronous pulse in the middle of a cycle; outputs must clear at once
  task automatic do_reset();
    #3;
    rst = 1'b1;
    #1;
    check_zero();
    q.delete();
    m_last = NCH - 1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // one clock: check grant before the edge, results and inflight after it
  task automatic cycle();
    logic [NCH-1:0] exp_ready;
    int             g;
    int             idx;
    bit             exp_rv;
    exp_t           e;
    #1;
    exp_ready = '0;
    g = -1;
    for (int k = 1; k <= NCH; k++) begin
      idx = (m_last + k) % NCH;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    if (g >= 0 && !rst) exp_ready[g] = 1'b1;
    check_val("req_ready", 64'(req_ready), 64'(exp_ready));
    if (g >= 0 && !rst) begin
      e.ch  = CHW'(g);
      e.op  = s_op[g];
      e.x   = s_x[g] + 18'd1;
      e.y   = ~s_y[g];
      e.p   = s_p[g];
      e.due = cyc + 1 + LAT;
      q.push_back(e);
      m_last = g;
    end
    @(posedge clk);
    cyc++;
    #1;
    exp_rv = (q.size() > 0) && (q[0].due == cyc);
    check_val("res_valid", 64'(res_valid), 64'(exp_rv));
    if (exp_rv) begin
      e = q.pop_front();
      if (res_valid) begin
        check_val("res_ch", 64'(res_ch), 64'(e.ch));
        check_val("res_op", 64'(res_op), 64'(e.op));
        check_val("res_x", 64'(res_x), 64'(e.x));
        check_val("res_y", 64'(res_y), 64'(e.y));
        check_val("res_p", 64'(res_p), 64'(e.p));
      end
    end
    check_val("inflight", 64'(inflight), 64'(q.size()));
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [1:0] op,
                        input logic [W-1:0] x, input logic [W-1:0] y, input logic [W:0] p);
    req_valid[ch] = v;
    s_op[ch] = op;
    s_x[ch]  = x;
    s_y[ch]  = y;
    s_p[ch]  = p;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    m_last  = NCH - 1;
    rst     = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b0, 2'd0, 18'd0, 18'd0, 19'd0);
    #3;
    check_zero();
    #9;
    rst = 1'b0;

    // single request on ch2
    for (int i = 0; i < 9; i++) cycle();
    set_ch(2, 1'b1, 2'd1, 18'd19584, 18'd0, 19'd0);
    cycle();
    req_valid = '0;
    for (int i = 0; i < LAT + 3; i++) cycle();

    // saturation from a fresh reset: grants 0,1,2,3,...
    do_reset();
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 2'(i), 18'(100 + i), 18'(200 + i), 19'(300 + i));
    #1;
    check_val("sat_first_grant", 64'(req_ready), 64'd1);
    for (int c = 0; c < 100; c++) begin
      cycle();
      for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 2'(c + i), 18'(c * 7 + i), 18'(c * 3 + i), 19'(c * 11 + i));
    end
    check_val("sat_inflight", 64'(inflight), 64'd21);
    req_valid = '0;
    for (int i = 0; i < LAT + 2; i++) cycle();

    // fairness: ch1 and ch3 alternate, then ch1 alone
    set_ch(1, 1'b1, 2'd2, 18'd11, 18'd12, 19'd13);
    set_ch(3, 1'b1, 2'd3, 18'd31, 18'd32, 19'd33);
    for (int i = 0; i < 8; i++) cycle();
    req_valid[3] = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    req_valid = '0;

    // op passthrough: ch0 alternating op 3 and op 1
    for (int i = 0; i < 10; i++) begin
      set_ch(0, 1'b1, (i % 2 == 0) ? 2'd3 : 2'd1, 18'(i), 18'(i + 50), 19'(i + 90));
      cycle();
    end
    req_valid = '0;
    for (int i = 0; i < LAT + 2; i++) cycle();

    // reset mid-flight: 10 requests lost, then one request after reset
    for (int i = 0; i < 10; i++) begin
      set_ch(0, 1'b1, 2'd1, 18'(1000 + i), 18'(i), 19'(i));
      cycle();
    end
    req_valid = '0;
    for (int i = 0; i < 5; i++) cycle();
    set_ch(1, 1'b1, 2'd2, 18'd777, 18'd555, 19'd333);
    do_reset();
    cycle();
    req_valid = '0;
    for (int i = 0; i < 30; i++) cycle();

    // random soak
    for (int c = 0; c < 8000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        set_ch(i, 1'($urandom_range(0, 1)), 2'($urandom), 18'($urandom), 18'($urandom), 19'($urandom));
      end
      cycle();
    end
    req_valid = '0;
    for (int i = 0; i < LAT + 2; i++) cycle();
    check_val("drain_empty", 64'(inflight), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
